// File: rtl/mc_control_unit.sv
// Multi-cycle control unit for the 16-bit RISC core.
// Sequences fetch/decode/execute/memory/writeback and drives datapath strobes.
module mc_control_unit #(
    parameter int PC_WIDTH  = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 imem_req,
    input  logic                 imem_ack,
    input  logic [PC_WIDTH-1:0]  imem_rdata,
    output logic [PC_WIDTH-1:0]  ir,
    output logic [2:0]           alu_ctrl,
    output logic                 alu_src_b,
    input  logic                 zero,
    output logic                 reg_we,
    output logic                 mem_to_reg,
    output logic                 pc_we,
    output logic [1:0]           pc_sel,
    output logic                 dmem_req,
    output logic                 dmem_we,
    input  logic                 dmem_ack,
    output logic                 retire,
    output logic [CNT_WIDTH-1:0] retired_count,
    output logic                 illegal
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]           state_q, state_d;
    logic [PC_WIDTH-1:0]  ir_q, ir_d;
    logic [CNT_WIDTH-1:0] retired_count_q, retired_count_d;

    logic [3:0] opcode;
    logic       is_ld, is_st, is_alu, is_beq, is_bne, is_jmp, is_ill;
    logic [2:0] dec_alu_ctrl;
    logic       dec_alu_src_b;
    logic       br_taken;

    assign opcode = ir_q[PC_WIDTH-1 -: 4];

    always_comb begin
        is_ld         = 1'b0;
        is_st         = 1'b0;
        is_alu        = 1'b0;
        is_beq        = 1'b0;
        is_bne        = 1'b0;
        is_jmp        = 1'b0;
        is_ill        = 1'b0;
        dec_alu_ctrl  = 3'b000;
        dec_alu_src_b = 1'b0;
        case (opcode)
            4'b0000: begin
                is_ld         = 1'b1;
                dec_alu_src_b = 1'b1;
            end
            4'b0001: begin
                is_st         = 1'b1;
                dec_alu_src_b = 1'b1;
            end
            4'b0010, 4'b0011, 4'b0100, 4'b0101,
            4'b0110, 4'b0111, 4'b1000, 4'b1001: begin
                is_alu       = 1'b1;
                // R-type opcodes 0010..1001 map linearly onto ALU ops 000..111
                dec_alu_ctrl = 3'(opcode - 4'b0010);
            end
            4'b1011: begin
                is_beq       = 1'b1;
                dec_alu_ctrl = 3'b001;
            end
            4'b1100: begin
                is_bne       = 1'b1;
                dec_alu_ctrl = 3'b001;
            end
            4'b1101: is_jmp = 1'b1;
            default: is_ill = 1'b1;
        endcase
    end

    assign br_taken = (is_beq && zero) || (is_bne && !zero);

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        reg_we     = 1'b0;
        mem_to_reg = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = PC_SEQ;
        retire     = 1'b0;
        illegal    = 1'b0;
        alu_ctrl   = 3'b000;
        alu_src_b  = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_ctrl  = dec_alu_ctrl;
                alu_src_b = dec_alu_src_b;
                if (is_ill) begin
                    state_d = S_TRAP;
                end else if (is_jmp) begin
                    pc_we   = 1'b1;
                    pc_sel  = PC_JMP;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_ctrl  = dec_alu_ctrl;
                alu_src_b = dec_alu_src_b;
                if (is_ld || is_st) begin
                    state_d = S_MEM;
                end else if (is_beq || is_bne) begin
                    pc_we   = br_taken;
                    pc_sel  = br_taken ? PC_BR : PC_SEQ;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                alu_ctrl  = dec_alu_ctrl;
                alu_src_b = dec_alu_src_b;
                dmem_req  = 1'b1;
                dmem_we   = is_st;
                if (dmem_ack) begin
                    retire  = is_st;
                    state_d = is_st ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                alu_ctrl   = dec_alu_ctrl;
                alu_src_b  = dec_alu_src_b;
                reg_we     = 1'b1;
                mem_to_reg = is_ld;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP: illegal = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        retired_count_d = retired_count_q;
        if (retire) begin
            retired_count_d = retired_count_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            ir_q            <= '0;
            retired_count_q <= '0;
        end else begin
            state_q         <= state_d;
            ir_q            <= ir_d;
            retired_count_q <= retired_count_d;
        end
    end

    assign ir            = ir_q;
    assign retired_count = retired_count_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: vector table with expected-result queue,
// plus reset, trap and counter-wrap sequences.
module tb_mc_control_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ack = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic [15:0] ir;
    logic [2:0]  alu_ctrl;
    logic        alu_src_b, zero = 1'b0;
    logic        reg_we, mem_to_reg, pc_we;
    logic [1:0]  pc_sel;
    logic        dmem_req, dmem_we, dmem_ack = 1'b0;
    logic        retire, illegal;
    logic [15:0] retired_count;

    logic        n_imem_req, n_alu_src_b, n_reg_we, n_mem_to_reg, n_pc_we;
    logic        n_dmem_req, n_dmem_we, n_retire, n_illegal;
    logic [15:0] n_ir;
    logic [2:0]  n_alu_ctrl;
    logic [1:0]  n_pc_sel;
    logic [3:0]  n_cnt;

    always #5 clk = ~clk;

    mc_control_unit #(.PC_WIDTH(16), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ir(ir), .alu_ctrl(alu_ctrl), .alu_src_b(alu_src_b), .zero(zero),
        .reg_we(reg_we), .mem_to_reg(mem_to_reg), .pc_we(pc_we),
        .pc_sel(pc_sel), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_ack(dmem_ack), .retire(retire),
        .retired_count(retired_count), .illegal(illegal)
    );

    // Narrow-counter copy so the wrap can be reached in a few cycles
    mc_control_unit #(.PC_WIDTH(16), .CNT_WIDTH(4)) dut_n (
        .clk(clk), .rst_n(rst_n),
        .imem_req(n_imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ir(n_ir), .alu_ctrl(n_alu_ctrl), .alu_src_b(n_alu_src_b), .zero(zero),
        .reg_we(n_reg_we), .mem_to_reg(n_mem_to_reg), .pc_we(n_pc_we),
        .pc_sel(n_pc_sel), .dmem_req(n_dmem_req), .dmem_we(n_dmem_we),
        .dmem_ack(dmem_ack), .retire(n_retire),
        .retired_count(n_cnt), .illegal(n_illegal)
    );

    typedef struct {
        logic [15:0] instr;
        int          iw;
        int          dw;
        logic        z;
        int          lat;
        logic [2:0]  alu;
        logic        srcb;
        int          dcyc;
        logic        dwe;
        logic        rwe;
        logic        m2r;
        logic        pcwe;
        logic [1:0]  pcsel;
    } vec_t;

    vec_t vt[18];
    vec_t sb[$];
    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] instr, input int iw, input int dw,
                                input logic z, input int lat, input logic [2:0] alu,
                                input logic srcb, input int dcyc, input logic dwe,
                                input logic rwe, input logic m2r, input logic pcwe,
                                input logic [1:0] pcsel);
        vec_t v;
        v.instr = instr; v.iw = iw; v.dw = dw; v.z = z; v.lat = lat;
        v.alu = alu; v.srcb = srcb; v.dcyc = dcyc; v.dwe = dwe;
        v.rwe = rwe; v.m2r = m2r; v.pcwe = pcwe; v.pcsel = pcsel;
        return v;
    endfunction

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_cnt = 0;
        @(negedge clk);
        chk("rst_strobes", {imem_req, dmem_req, dmem_we, reg_we, pc_we, retire,
                            illegal, mem_to_reg, alu_src_b}, 0);
        chk("rst_alu_ctrl", alu_ctrl, 0);
        chk("rst_pc_sel", pc_sel, 0);
        chk("rst_ir", ir, 0);
        chk("rst_count", retired_count, 0);
        chk("rst_count_n", n_cnt, 0);
    endtask

    task automatic run_instr(input vec_t v);
        vec_t e;
        int lat = 0, pre = 0, dcyc = 0, ph = 0, iwc = 0, dwc = 0, c = 0;
        logic started = 0, fetched = 0, done = 0, fpc = 0;
        logic dwe = 0, rwe = 0, m2r = 0, pcwe = 0, srcb = 0;
        logic [1:0] pcsel = 0;
        logic [2:0] alu = 0;
        logic [15:0] ir_seen = 0;
        sb.push_back(v);
        while (!done && c < 80) begin
            c++;
            @(posedge clk);
            #1;
            imem_ack = 1'b0;
            dmem_ack = 1'b0;
            imem_rdata = v.instr;
            zero = v.z;
            if (imem_req) begin
                started = 1;
                if (iwc == v.iw) imem_ack = 1'b1;
                else iwc++;
            end
            if (dmem_req) begin
                if (dwc == v.dw) dmem_ack = 1'b1;
                else dwc++;
            end
            @(negedge clk);
            if (started) lat++;
            else pre++;
            if (dmem_req) dcyc++;
            if (dmem_req && dmem_we) dwe = 1;
            if (reg_we) begin
                rwe = 1;
                m2r = mem_to_reg;
            end
            if (fetched) ph++;
            if (imem_req && imem_ack) begin
                fetched = 1;
                ph = 0;
                fpc = pc_we && (pc_sel == 2'b00);
            end
            if (fetched && ph == 2) begin
                alu = alu_ctrl;
                srcb = alu_src_b;
            end
            if (retire) begin
                done = 1;
                pcwe = pc_we;
                pcsel = pc_sel;
                ir_seen = ir;
                chk("count", retired_count, exp_cnt[15:0]);
                chk("count_n", n_cnt, exp_cnt[3:0]);
                exp_cnt++;
            end
        end
        if (!done) begin
            chk("retire_timeout", 0, 1);
            void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            chk("fetch_gap", pre, 0);
            chk("fetch_pc_we", fpc, 1);
            chk("ir", ir_seen, e.instr);
            chk("latency", lat, e.lat);
            chk("alu_ctrl", alu, e.alu);
            chk("alu_src_b", srcb, e.srcb);
            chk("dmem_cycles", dcyc, e.dcyc);
            chk("dmem_we", dwe, e.dwe);
            chk("reg_we", rwe, e.rwe);
            chk("mem_to_reg", m2r, e.m2r);
            chk("pc_we", pcwe, e.pcwe);
            chk("pc_sel", pcsel, e.pcsel);
        end
    endtask

    initial begin
        int c;
        logic hit;
        vt[0]  = mk(16'h2298, 0, 0, 0, 4, 3'd0, 0, 0, 0, 1, 0, 0, 2'b00);
        vt[1]  = mk(16'h3298, 0, 0, 1, 4, 3'd1, 0, 0, 0, 1, 0, 0, 2'b00);
        vt[2]  = mk(16'h4298, 0, 0, 0, 4, 3'd2, 0, 0, 0, 1, 0, 0, 2'b00);
        vt[3]  = mk(16'h5298, 0, 0, 1, 4, 3'd3, 0, 0, 0, 1, 0, 0, 2'b00);
        vt[4]  = mk(16'h6298, 0, 0, 0, 4, 3'd4, 0, 0, 0, 1, 0, 0, 2'b00);
        vt[5]  = mk(16'h7298, 0, 0, 1, 4, 3'd5, 0, 0, 0, 1, 0, 0, 2'b00);
        vt[6]  = mk(16'h8298, 0, 0, 0, 4, 3'd6, 0, 0, 0, 1, 0, 0, 2'b00);
        vt[7]  = mk(16'h9298, 0, 0, 1, 4, 3'd7, 0, 0, 0, 1, 0, 0, 2'b00);
        vt[8]  = mk(16'h0245, 0, 3, 0, 8, 3'd0, 1, 4, 0, 1, 1, 0, 2'b00);
        vt[9]  = mk(16'h1245, 0, 3, 0, 7, 3'd0, 1, 4, 1, 0, 0, 0, 2'b00);
        vt[10] = mk(16'hB123, 0, 0, 1, 3, 3'd1, 0, 0, 0, 0, 0, 1, 2'b01);
        vt[11] = mk(16'hB123, 0, 0, 0, 3, 3'd1, 0, 0, 0, 0, 0, 0, 2'b00);
        vt[12] = mk(16'hC123, 0, 0, 0, 3, 3'd1, 0, 0, 0, 0, 0, 1, 2'b01);
        vt[13] = mk(16'hC123, 0, 0, 1, 3, 3'd1, 0, 0, 0, 0, 0, 0, 2'b00);
        vt[14] = mk(16'hD123, 0, 0, 1, 2, 3'd0, 0, 0, 0, 0, 0, 1, 2'b10);
        vt[15] = mk(16'h2298, 2, 0, 0, 6, 3'd0, 0, 0, 0, 1, 0, 0, 2'b00);
        vt[16] = mk(16'h0245, 0, 0, 0, 5, 3'd0, 1, 1, 0, 1, 1, 0, 2'b00);
        vt[17] = mk(16'h1245, 0, 0, 0, 4, 3'd0, 1, 1, 1, 0, 0, 0, 2'b00);

        do_reset();
        foreach (vt[i]) run_instr(vt[i]);

        // JMP stream walks the 4-bit counter copy through its wrap
        for (int i = 0; i < 20; i++) run_instr(vt[14]);

        // Reset while a load waits in MEM
        c = 0;
        hit = 0;
        while (!hit && c < 20) begin
            c++;
            @(posedge clk);
            #1;
            imem_rdata = 16'h0245;
            imem_ack = imem_req;
            dmem_ack = 1'b0;
            @(negedge clk);
            hit = dmem_req;
        end
        chk("mem_reached", hit, 1);
        repeat (2) begin
            @(posedge clk);
            #1;
            imem_ack = 1'b0;
            dmem_ack = 1'b0;
        end
        do_reset();

        // Illegal opcode traps and stays trapped
        c = 0;
        hit = 0;
        while (!hit && c < 20) begin
            c++;
            @(posedge clk);
            #1;
            imem_rdata = 16'hE000;
            imem_ack = imem_req;
            dmem_ack = 1'b0;
            @(negedge clk);
            hit = illegal;
        end
        chk("trap_reached", hit, 1);
        repeat (20) begin
            @(posedge clk);
            #1;
            imem_ack = 1'($urandom_range(0, 1));
            dmem_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("trap_hold", {illegal, imem_req, dmem_req, dmem_we, reg_we,
                              pc_we, retire}, 7'b1000000);
        end
        do_reset();

        // One more instruction to confirm the unit restarts after a trap
        run_instr(vt[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multi-cycle control unit for the 16-bit RISC core. It fetches instructions over a req/ack handshake and holds them in an internal instruction register. It sequences each instruction through fetch/decode/execute/memory/writeback. It drives the ALU's `alu_ctrl`, consumes the ALU's `zero` flag for branches, and issues register-file, PC and data-memory strobes.

## Interface
Parameters:
- PC_WIDTH, 16, instruction/data width; also the width of `ir` and `imem_rdata`
- CNT_WIDTH, 16, width of the retired-instruction counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset; one clock, reset is synchronous and active-low
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch complete; `imem_rdata` valid this cycle
- imem_rdata  in  PC_WIDTH  fetched instruction
- ir  out  PC_WIDTH  instruction register; the datapath slices register fields from it
- alu_ctrl  out  3  ALU operation select
- alu_src_b  out  1  0: ALU B = register rs2; 1: B = sign-extended ir[5:0]
- zero  in  1  ALU zero flag
- reg_we  out  1  register-file write strobe
- mem_to_reg  out  1  writeback source; 1 = load data, 0 = ALU result
- pc_we  out  1  PC update strobe
- pc_sel  out  2  next-PC source: 00 PC+2, 01 branch target, 10 jump target
- dmem_req  out  1  data-memory request
- dmem_we  out  1  data-memory write (meaningful only while `dmem_req` = 1)
- dmem_ack  in  1  data access complete
- retire  out  1  one-cycle pulse per completed instruction
- retired_count  out  CNT_WIDTH  retired-instruction count
- illegal  out  1  trap flag, sticky until reset

## Operation
Opcode is ir[15:12]. Decode as follows:
- 0000 LD, 0001 ST: alu_ctrl 000, alu_src_b 1
- 0010 ADD 000, 0011 SUB 001, 0100 INV 010, 0101 LSL 011, 0110 LSR 100, 0111 AND 101, 1000 OR 110, 1001 SLT 111; alu_src_b 0
- 1011 BEQ, 1100 BNE: alu_ctrl 001, alu_src_b 0
- 1101 JMP
- 1010, 1110, 1111: illegal

States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. All outputs except `ir`/`retired_count` are Moore decodes of state plus `ir`. The exception is the ack-qualified strobes noted below.

Transitions:
- IDLE -> FETCH unconditionally.
- FETCH:
  - `imem_req`=1 until `imem_ack`.
  - On ack: `ir` <= `imem_rdata`, `pc_we`=1, `pc_sel`=00 in that cycle; -> DECODE.
- DECODE:
  - Illegal opcode -> TRAP.
  - JMP: `pc_we`=1, `pc_sel`=10, `retire`=1; -> FETCH.
  - Otherwise -> EXEC.
- EXEC:
  - R-type -> WB.
  - LD/ST -> MEM.
  - BEQ: `pc_we`=1, `pc_sel`=01 iff `zero`=1. BNE: the same iff `zero`=0. Either branch: `retire`=1; -> FETCH.
- MEM:
  - `dmem_req`=1 until `dmem_ack`; `dmem_we`=1 for ST.
  - On ack: ST retires -> FETCH; LD -> WB.
- WB: `reg_we`=1; `mem_to_reg`=1 for LD; `retire`=1; -> FETCH.
- TRAP: `illegal`=1; all req/we strobes 0; stays until reset.

Output and counter rules:
- `alu_ctrl`/`alu_src_b` reflect the decoded `ir` from DECODE through WB. They are 000/0 in IDLE, FETCH and TRAP.
- `retired_count` increments on each `retire` and wraps 2^CNT_WIDTH-1 -> 0.
- Acks are ignored when the matching req is 0.

## Timing
- Reset values, in effect on the edge after `rst_n` sampled low:
  - state IDLE; `ir`=0, `retired_count`=0.
  - All strobes 0: `imem_req`, `dmem_req`, `dmem_we`, `reg_we`, `pc_we`, `retire`.
  - `alu_ctrl`=000, `alu_src_b`=0, `mem_to_reg`=0, `pc_sel`=00, `illegal`=0.
- First `imem_req` is asserted 2 cycles after `rst_n` is sampled high (IDLE, then FETCH).
- Zero-wait ack (same cycle as req) is legal. Each extra wait cycle adds one cycle to FETCH or MEM.
- Latency with zero-wait memories, FETCH to retire inclusive: JMP 2, BEQ/BNE 3, R-type 4, ST 4, LD 5 cycles.
- `zero` is sampled only in EXEC of a branch.
- Reset mid-instruction: abandoned at the next edge. No strobe is asserted after that edge, and `retired_count` clears.

## Test plan
- Reset, then ADD instr 0x2298, zero-wait imem:
  - `imem_req` high on the 2nd cycle after reset release.
  - `pc_we`/`pc_sel`=00 on ack; `alu_ctrl`=000 in EXEC.
  - `reg_we` in WB; `retire` on cycle 4; `retired_count`=1.
- Each ALU opcode 0010-1001 -> `alu_ctrl` 000..111 respectively in EXEC, with `alu_src_b`=0.
- LD 0x0245 with `dmem_ack` delayed 3 cycles:
  - `dmem_req`=1 and `dmem_we`=0 for 4 cycles; `alu_src_b`=1.
  - WB has `reg_we`=1 and `mem_to_reg`=1.
  - ST retires on ack with `dmem_we`=1 and no `reg_we`.
- Branches:
  - BEQ with `zero`=1 -> `pc_we`=1, `pc_sel`=01; with `zero`=0 -> no `pc_we`; both retire in 3 cycles.
  - BNE gives the inverse.
  - JMP -> `pc_sel`=10 in DECODE.
- Opcode 0xE -> TRAP:
  - `illegal`=1 and `imem_req` stays 0 for 20 cycles.
  - Stray acks are ignored.
  - Reset clears `illegal`.
- Preload `retired_count` to 0xFFFF via 65535 retires -> next retire wraps to 0x0000. Reset asserted during MEM -> `dmem_req` low after the next edge.
